// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - scan-position and sync bundle between the raster generator and the drawing stages
//
// Purpose: carries the raster position, visibility flag, sync pulses and the
// frame marker from vga_timing_gen (master) to the sprite/palette stages and
// VGA pins (slave).
// Signals:
//   DrawX       [9:0] horizontal position, 0..H_TOTAL-1
//   DrawY       [9:0] vertical position, 0..V_TOTAL-1
//   blank             1 = visible pixel, 0 = blanking
//   hs                horizontal sync, active low, delayed
//   vs                vertical sync, active low, delayed
//   frame_start       one-cycle pulse at (0,0)
interface vga_timing_gen_if;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       blank;
   logic       hs;
   logic       vs;
   logic       frame_start;

   modport master (
      output DrawX,
      output DrawY,
      output blank,
      output hs,
      output vs,
      output frame_start
   );

   modport slave (
      input DrawX,
      input DrawY,
      input blank,
      input hs,
      input vs,
      input frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster timing generator with delayed sync
//
// Purpose: free-running horizontal/vertical counters giving the scan position,
// a registered visibility flag and frame marker aligned with that position,
// and hs/vs sync delayed by SYNC_DELAY cycles to line up with registered RGB.
// Ports:
//   vga_clk   in   pixel clock, all logic on the rising edge
//   reset_n   in   synchronous active-low reset
//   vga       out  master side of vga_timing_gen_if (DrawX, DrawY, blank,
//                  hs, vs, frame_start)
module vga_timing_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int SYNC_DELAY = 1
) (
   input logic              vga_clk,
   input logic              reset_n,
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // All compare constants are 10-bit so every comparison is unsigned 10-bit.
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [9:0] hc_q, hc_d;
   logic [9:0] vc_q, vc_d;
   logic       blank_q, blank_d;
   logic       fs_q, fs_d;
   logic       hraw_q, hraw_d;
   logic       vraw_q, vraw_d;

   // Flags are decoded from the next counter values so that, once registered,
   // they describe the same pixel as hc_q/vc_q.
   always_comb begin
      hc_d = hc_q + 10'd1;
      vc_d = vc_q;
      if (hc_q == H_LAST) begin
         hc_d = '0;
         vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
      end
      blank_d = (hc_d < H_VIS) && (vc_d < V_VIS);
      fs_d    = (hc_d == '0) && (vc_d == '0);
      hraw_d  = !((hc_d >= HS_FIRST) && (hc_d <= HS_LAST));
      vraw_d  = !((vc_d >= VS_FIRST) && (vc_d <= VS_LAST));
   end

   // Reset state is pixel (0,0) of a frame, so blank and frame_start are set.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         hc_q    <= '0;
         vc_q    <= '0;
         blank_q <= 1'b1;
         fs_q    <= 1'b1;
         hraw_q  <= 1'b1;
         vraw_q  <= 1'b1;
      end else begin
         hc_q    <= hc_d;
         vc_q    <= vc_d;
         blank_q <= blank_d;
         fs_q    <= fs_d;
         hraw_q  <= hraw_d;
         vraw_q  <= vraw_d;
      end
   end

   assign vga.DrawX       = hc_q;
   assign vga.DrawY       = vc_q;
   assign vga.blank       = blank_q;
   assign vga.frame_start = fs_q;

   generate
      if (SYNC_DELAY == 0) begin : g_no_delay
         assign vga.hs = hraw_q;
         assign vga.vs = vraw_q;
      end else begin : g_delay
         logic [SYNC_DELAY-1:0] hs_dly_q;
         logic [SYNC_DELAY-1:0] vs_dly_q;

         // Filling with 1 on reset keeps sync inactive for SYNC_DELAY cycles
         // after any reset, whatever was in flight.
         always_ff @(posedge vga_clk) begin
            if (!reset_n) begin
               hs_dly_q <= '1;
               vs_dly_q <= '1;
            end else begin
               hs_dly_q[0] <= hraw_q;
               vs_dly_q[0] <= vraw_q;
               for (int i = 1; i < SYNC_DELAY; i++) begin
                  hs_dly_q[i] <= hs_dly_q[i-1];
                  vs_dly_q[i] <= vs_dly_q[i-1];
               end
            end
         end

         assign vga.hs = hs_dly_q[SYNC_DELAY-1];
         assign vga.vs = vs_dly_q[SYNC_DELAY-1];
      end
   endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

   logic clk   = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   always #20 clk = ~clk;

   vga_timing_gen_if if_d1();
   vga_timing_gen_if if_d0();
   vga_timing_gen_if if_d3();
   vga_timing_gen_if if_s();

   vga_timing_gen #(.SYNC_DELAY(1)) u_d1 (.vga_clk(clk), .reset_n(rst_a), .vga(if_d1));
   vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (.vga_clk(clk), .reset_n(rst_a), .vga(if_d0));
   vga_timing_gen #(.SYNC_DELAY(3)) u_d3 (.vga_clk(clk), .reset_n(rst_a), .vga(if_d3));
   // Reduced raster (32x19 = 608 cycles per frame) for frame-level behaviour.
   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .SYNC_DELAY(2)
   ) u_s (.vga_clk(clk), .reset_n(rst_b), .vga(if_s));

   typedef struct {
      int   n;
      int   x;
      int   y;
      logic b;
      logic h1;
      logic h0;
      logic h3;
      logic fs;
   } vec_rec_t;

   vec_rec_t tbl[17];

   int checks   = 0;
   int failures = 0;
   int na = 0;
   int nb = 0;
   logic [23:0] exp_q[$];

   int hlow_d1 = 0, hlow_d0 = 0, hlow_d3 = 0;
   int s_fs = 0, s_vlow = 0, s_vrun = 0, s_vmax = 0, s_blank_bad = 0, s_ymax = 0;
   int s_wrap = 0;
   int s_px = 0, s_py = 0;

   // Expected outputs n edges after the last reset edge, from cycle arithmetic.
   function automatic logic [23:0] model(input int n, input int ha, input int hf,
                                         input int hsw, input int hb, input int va,
                                         input int vf, input int vsw, input int vb,
                                         input int d);
      int ht, vt, p, x, y, ps, xs, ys;
      logic b, h, v, f;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vb;
      p  = n % (ht * vt);
      x  = p % ht;
      y  = p / ht;
      b  = (x < ha) && (y < va);
      f  = (p == 0);
      if (n < d) begin
         h = 1'b1;
         v = 1'b1;
      end else begin
         ps = (n - d) % (ht * vt);
         xs = ps % ht;
         ys = ps / ht;
         h  = !((xs >= ha + hf) && (xs < ha + hf + hsw));
         v  = !((ys >= va + vf) && (ys < va + vf + vsw));
      end
      return {x[9:0], y[9:0], b, h, v, f};
   endfunction

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   task automatic chk_vec(input string name, input int n, input logic [23:0] act);
      logic [23:0] e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
         failures++;
         $display("FAIL %s n=%0d: got x=%0d y=%0d bhvf=%b expected x=%0d y=%0d bhvf=%b",
                  name, n, act[23:14], act[13:4], act[3:0], e[23:14], e[13:4], e[3:0]);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      na = rst_a ? na + 1 : 0;
      nb = rst_b ? nb + 1 : 0;
      exp_q.push_back(model(na, 640, 16, 96, 48, 480, 10, 2, 33, 1));
      exp_q.push_back(model(na, 640, 16, 96, 48, 480, 10, 2, 33, 0));
      exp_q.push_back(model(na, 640, 16, 96, 48, 480, 10, 2, 33, 3));
      exp_q.push_back(model(nb, 16, 4, 6, 6, 12, 2, 2, 3, 2));
      @(negedge clk);
      chk_vec("sb_d1", na, {if_d1.DrawX, if_d1.DrawY, if_d1.blank, if_d1.hs, if_d1.vs, if_d1.frame_start});
      chk_vec("sb_d0", na, {if_d0.DrawX, if_d0.DrawY, if_d0.blank, if_d0.hs, if_d0.vs, if_d0.frame_start});
      chk_vec("sb_d3", na, {if_d3.DrawX, if_d3.DrawY, if_d3.blank, if_d3.hs, if_d3.vs, if_d3.frame_start});
      chk_vec("sb_s", nb, {if_s.DrawX, if_s.DrawY, if_s.blank, if_s.hs, if_s.vs, if_s.frame_start});
      if (na < 800) begin
         if (!if_d1.hs) hlow_d1++;
         if (!if_d0.hs) hlow_d0++;
         if (!if_d3.hs) hlow_d3++;
      end
      if (nb >= 1 && nb <= 1216) begin
         if (if_s.frame_start) s_fs++;
         if (!if_s.vs) begin
            s_vlow++;
            s_vrun++;
            if (s_vrun > s_vmax) s_vmax = s_vrun;
         end else begin
            s_vrun = 0;
         end
         if (int'(if_s.DrawY) >= 12 && if_s.blank) s_blank_bad++;
         if (int'(if_s.DrawY) > s_ymax) s_ymax = int'(if_s.DrawY);
         if (s_px == 31 && s_py == 18 && if_s.DrawX == 10'd0 && if_s.DrawY == 10'd0 && if_s.frame_start)
            s_wrap = 1;
      end
      s_px = int'(if_s.DrawX);
      s_py = int'(if_s.DrawY);
   endtask

   initial begin
      //        n     x    y  b  h1 h0 h3 fs
      tbl[0]  = '{5,    5,   0, 1, 1, 1, 1, 0};
      tbl[1]  = '{639,  639, 0, 1, 1, 1, 1, 0};
      tbl[2]  = '{640,  640, 0, 0, 1, 1, 1, 0};
      tbl[3]  = '{655,  655, 0, 0, 1, 1, 1, 0};
      tbl[4]  = '{656,  656, 0, 0, 1, 0, 1, 0};
      tbl[5]  = '{657,  657, 0, 0, 0, 0, 1, 0};
      tbl[6]  = '{658,  658, 0, 0, 0, 0, 1, 0};
      tbl[7]  = '{659,  659, 0, 0, 0, 0, 0, 0};
      tbl[8]  = '{751,  751, 0, 0, 0, 0, 0, 0};
      tbl[9]  = '{752,  752, 0, 0, 0, 1, 0, 0};
      tbl[10] = '{753,  753, 0, 0, 1, 1, 0, 0};
      tbl[11] = '{754,  754, 0, 0, 1, 1, 0, 0};
      tbl[12] = '{755,  755, 0, 0, 1, 1, 1, 0};
      tbl[13] = '{799,  799, 0, 0, 1, 1, 1, 0};
      tbl[14] = '{800,  0,   1, 1, 1, 1, 1, 0};
      tbl[15] = '{1439, 639, 1, 1, 1, 1, 1, 0};
      tbl[16] = '{1440, 640, 1, 0, 1, 1, 1, 0};

      // Reset held for three cycles.
      repeat (3) cycle();
      chk("rst_x", int'(if_d1.DrawX), 0);
      chk("rst_y", int'(if_d1.DrawY), 0);
      chk("rst_blank", int'(if_d1.blank), 1);
      chk("rst_hs", int'(if_d1.hs), 1);
      chk("rst_vs", int'(if_d1.vs), 1);
      chk("rst_fs", int'(if_d1.frame_start), 1);
      chk("rst_s_fs", int'(if_s.frame_start), 1);

      rst_a = 1'b1;
      rst_b = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         cycle();
         chk($sformatf("rel_x%0d", k), int'(if_d1.DrawX), k);
         chk($sformatf("rel_fs%0d", k), int'(if_d1.frame_start), 0);
      end

      // Line timing and sync alignment for delays 1, 0 and 3.
      for (int i = 0; i < 17; i++) begin
         while (na < tbl[i].n) cycle();
         chk($sformatf("tbl%0d_x", i), int'(if_d1.DrawX), tbl[i].x);
         chk($sformatf("tbl%0d_y", i), int'(if_d1.DrawY), tbl[i].y);
         chk($sformatf("tbl%0d_blank", i), int'(if_d1.blank), int'(tbl[i].b));
         chk($sformatf("tbl%0d_hs_d1", i), int'(if_d1.hs), int'(tbl[i].h1));
         chk($sformatf("tbl%0d_hs_d0", i), int'(if_d0.hs), int'(tbl[i].h0));
         chk($sformatf("tbl%0d_hs_d3", i), int'(if_d3.hs), int'(tbl[i].h3));
         chk($sformatf("tbl%0d_fs", i), int'(if_d1.frame_start), int'(tbl[i].fs));
      end
      chk("hs_width_d1", hlow_d1, 96);
      chk("hs_width_d0", hlow_d0, 96);
      chk("hs_width_d3", hlow_d3, 96);

      // Frame-level results on the reduced raster (two full frames observed).
      chk("s_frame_pulses", s_fs, 2);
      chk("s_vs_low_total", s_vlow, 128);
      chk("s_vs_low_run", s_vmax, 64);
      chk("s_blank_in_vblank", s_blank_bad, 0);
      chk("s_ymax", s_ymax, 18);
      chk("s_wrap_seen", s_wrap, 1);

      // Mid-frame reset inside both sync pulses: (25,15) of the third frame.
      while (nb < 1216 + 15 * 32 + 25) cycle();
      chk("mid_pre_x", int'(if_s.DrawX), 25);
      chk("mid_pre_y", int'(if_s.DrawY), 15);
      chk("mid_pre_hs", int'(if_s.hs), 0);
      chk("mid_pre_vs", int'(if_s.vs), 0);
      rst_b = 1'b0;
      cycle();
      chk("mid_rst_x", int'(if_s.DrawX), 0);
      chk("mid_rst_y", int'(if_s.DrawY), 0);
      chk("mid_rst_hs", int'(if_s.hs), 1);
      chk("mid_rst_vs", int'(if_s.vs), 1);
      chk("mid_rst_fs", int'(if_s.frame_start), 1);
      rst_b = 1'b1;
      cycle();
      chk("mid_post_x", int'(if_s.DrawX), 1);
      chk("mid_post_y", int'(if_s.DrawY), 0);
      chk("mid_post_hs", int'(if_s.hs), 1);
      chk("mid_post_vs", int'(if_s.vs), 1);
      chk("mid_post_fs", int'(if_s.frame_start), 0);
      repeat (40) cycle();
      chk("mid_late_x", int'(if_s.DrawX), 41 % 32);
      chk("mid_late_y", int'(if_s.DrawY), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480@60 Hz VGA output. It drives the `DrawX`/`DrawY`/`blank` scan position consumed by every sprite/palette drawing stage, and generates `hs`/`vs` sync. The sync outputs are delayed by a programmable number of cycles so they stay aligned with the registered RGB those stages produce. It sits directly upstream of the sprite drawing stages, and its sync outputs go straight to the VGA pins.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_DELAY`, 1, pipeline delay (cycles, 0..7) applied to `hs`/`vs` to match the drawing-stage latency
- `vga_clk`  input  1  pixel clock, 25 MHz; all logic on rising edge
- `reset_n`  input  1  synchronous, active-low reset; one clock, with synchronous active-low reset
- `DrawX`  output  10  current horizontal counter (0..H_TOTAL-1)
- `DrawY`  output  10  current vertical counter (0..V_TOTAL-1)
- `blank`  output  1  1 = visible pixel (DrawX < H_ACTIVE and DrawY < V_ACTIVE), 0 = blanking
- `hs`  output  1  horizontal sync, active low, delayed SYNC_DELAY cycles
- `vs`  output  1  vertical sync, active low, delayed SYNC_DELAY cycles
- `frame_start`  output  1  one-cycle pulse when DrawX=0 and DrawY=0

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Both totals must be ≤ 1024. All counter comparisons are unsigned 10-bit.
- Horizontal counter `hc` (10-bit register):
  - Increments every cycle.
  - At H_TOTAL-1 it wraps to 0 and asserts the line-wrap condition.
- Vertical counter `vc` (10-bit register):
  - Increments only on line wrap.
  - At V_TOTAL-1 with line wrap, it wraps to 0.
- `DrawX` = `hc` and `DrawY` = `vc`, driven directly from the registers (no extra latency).
- `blank`, `frame_start` and raw sync are decoded combinationally from the *next* counter values and registered, so they are cycle-aligned with `DrawX`/`DrawY`.
- Raw hsync is low iff H_ACTIVE+H_FP ≤ hc ≤ H_ACTIVE+H_FP+H_SYNC-1 (656..751).
- Raw vsync is low iff V_ACTIVE+V_FP ≤ vc ≤ V_ACTIVE+V_FP+V_SYNC-1 (490..491), across whole lines.
- Raw hsync/vsync pass through a SYNC_DELAY-deep shift register to produce `hs`/`vs`. SYNC_DELAY=0 means a direct wire from the raw registered sync.
- Non-visible DrawX/DrawY values are still emitted. Downstream stages must gate on `blank`.

## Timing
- Reset (`reset_n`=0 at a rising edge):
  - `hc`=0, `vc`=0, so `DrawX`=0 and `DrawY`=0.
  - `blank`=1 and `frame_start`=1: the reset state is the first pixel of a frame.
  - `hs`=1, `vs`=1, and all delay-line stages are filled with 1.
- First edge after release: `DrawX`=1, `blank`=1, `frame_start`=0.
- Reset asserted mid-frame: on that edge, every output takes its reset value, with no partial line completion. Sync outputs are inactive for the next SYNC_DELAY cycles regardless of what the delay line held.
- Line period: exactly H_TOTAL cycles. Frame period: exactly H_TOTAL×V_TOTAL cycles (420000).
- `frame_start` is high exactly one cycle per frame, in the same cycle as DrawX=0, DrawY=0.
- `blank` falls in the cycle DrawX=H_ACTIVE, and rises in the cycle DrawX=0 of lines 0..V_ACTIVE-1.
- `hs` falls SYNC_DELAY cycles after the cycle DrawX=656, and stays low for exactly H_SYNC cycles.
- `vs` falls SYNC_DELAY cycles after the cycle (DrawX=0, DrawY=490), and stays low for exactly V_SYNC×H_TOTAL cycles.
- Wrap boundaries:
  - DrawX=799 → 0 and DrawY+1 on the same edge.
  - (799,524) → (0,0) with `frame_start`=1 on that edge.

## Test plan
- Reset check: hold `reset_n`=0 for 3 cycles, then release.
  - During reset: DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_start=1.
  - After release: DrawX counts 1,2,3; frame_start=0.
- Line timing: run one line.
  - blank=1 for DrawX 0..639, 0 for 640..799.
  - With SYNC_DELAY=1, hs is low for exactly 96 cycles, from the cycle where DrawX=657 through DrawX=752.
- Frame wrap: run 420000 cycles from release.
  - DrawY reaches 524, then (0,0) follows.
  - frame_start pulses exactly once per 420000 cycles.
  - blank is 0 for every cycle with DrawY ≥ 480.
- Vsync: vs is low for exactly 1600 consecutive cycles, beginning SYNC_DELAY cycles after (DrawX=0, DrawY=490). It is high on all other cycles.
- Mid-frame reset: assert `reset_n`=0 for 1 cycle at (DrawX=700, DrawY=491), while hs=0 and vs=0.
  - Next outputs: DrawX=0, DrawY=0, hs=1, vs=1.
  - Normal sequence restarts from (1,0).
- Delay parameter sweep: SYNC_DELAY=0 and SYNC_DELAY=3.
  - The hs falling edge aligns with the DrawX=656 cycle and the DrawX=659 cycle respectively.
  - Pulse widths are unchanged.
